// File: rtl/switch_power_tester_output_pkg.sv
// Shared flit type codes, checker/rx state encodings and flow-control mode
// selection for the switch power test-bench output sink.
package switch_power_tester_output_pkg;

    localparam logic [2:0] FLIT_HEADER  = 3'b011;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b000;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic {RX_WAIT_HEADER, RX_IN_PACKET} chk_state_e;
    typedef enum logic {RX_ACCEPT, RX_DISCARD} rx_state_e;
    typedef enum logic {FC_STALLGO, FC_ACKNACK} fc_mode_e;

`ifdef ACKNACK
    localparam fc_mode_e FC_DEFAULT = FC_ACKNACK;
`else
    localparam fc_mode_e FC_DEFAULT = FC_STALLGO;
`endif

endpackage

// File: rtl/switch_power_tester_output_if.sv
// Forward flit channel plus the three backward flow-control wires of one
// switch output port.
interface switch_power_tester_output_if #(
    parameter int FLITWIDTH = 32
) ();
    logic [FLITWIDTH-1:0] FLIT_in;
    logic                 VALID_in;
    logic                 FWDAUX1_in;
    logic                 BWDAUX1_out;
    logic                 BWDAUX2_out;
    logic                 BWDAUX3_out;

    modport master (
        output FLIT_in, VALID_in, FWDAUX1_in,
        input  BWDAUX1_out, BWDAUX2_out, BWDAUX3_out
    );

    modport slave (
        input  FLIT_in, VALID_in, FWDAUX1_in,
        output BWDAUX1_out, BWDAUX2_out, BWDAUX3_out
    );
endinterface

// File: rtl/switch_power_rx_fifo_4.sv
// Four-entry flit FIFO; the caller owns all flow-control decisions, this block
// only guards against overflow/underflow.
module switch_power_rx_fifo_4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [2:0]       occupancy_o
);
    logic [WIDTH-1:0] mem [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       occ_q, occ_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (occ_q != 3'd4);
    assign do_pop  = pop_i && (occ_q != 3'd0);

    always_comb begin
        occ_d = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + 3'd1;
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - 3'd1;
        end
    end

    // 2-bit pointers wrap 3 -> 0 naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 3'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    assign data_o      = mem[rd_ptr_q];
    assign occupancy_o = occ_q;
endmodule

// File: rtl/switch_power_tester_output.sv
// Output-port traffic sink: buffers flits, drives STALL/GO or ACK/NACK back
// toward the switch, drains at a fixed rate and checks packet framing.
module switch_power_tester_output
    import switch_power_tester_output_pkg::*;
#(
    parameter int       FLITWIDTH        = 32,
    parameter int       LOGNUMBEROUTPUTS = 2,
    parameter int       DRAINPERIOD      = 1,
    parameter int       COUNTWIDTH       = 16,
    parameter fc_mode_e FC_MODE          = FC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LOGNUMBEROUTPUTS-1:0] ID,
    switch_power_tester_output_if.slave port_if,
    output logic [COUNTWIDTH-1:0]       flit_count,
    output logic [COUNTWIDTH-1:0]       packet_count,
    output logic                        protocol_error,
    output logic                        dest_error
);
    localparam int            DW         = (DRAINPERIOD > 1) ? $clog2(DRAINPERIOD) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAINPERIOD - 1);

    logic                  push, pop, full;
    logic [2:0]            occupancy;
    logic [FLITWIDTH-1:0]  fifo_out;
    logic [2:0]            pop_type;
    logic                  unused_flit_bits;
    logic [DW-1:0]         drain_q, drain_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_ack_q, rsp_ack_d;
    chk_state_e            chk_state_q, chk_state_d;
    logic [COUNTWIDTH-1:0] flit_count_q, flit_count_d, packet_count_q, packet_count_d;
    logic                  protocol_error_q, protocol_error_d, dest_error_q, dest_error_d;

    switch_power_rx_fifo_4 #(.WIDTH(FLITWIDTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .data_i      (port_if.FLIT_in),
        .data_o      (fifo_out),
        .occupancy_o (occupancy)
    );

    assign full             = (occupancy == 3'(FIFO_DEPTH));
    assign pop_type         = fifo_out[2:0];
    assign unused_flit_bits = ^fifo_out[FLITWIDTH-1:LOGNUMBEROUTPUTS+3];

    // A drain slot that finds the FIFO empty is simply lost, never deferred
    assign drain_d = (drain_q == DRAIN_LAST) ? '0 : drain_q + DW'(1);
    assign pop     = (drain_q == '0) && (occupancy != 3'd0);

    always_comb begin
        rx_state_d  = rx_state_q;
        push        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_ack_d   = 1'b0;
        if (FC_MODE == FC_STALLGO) begin
            push = port_if.VALID_in && !full;
        end else if (port_if.VALID_in && (rx_state_q == RX_ACCEPT || port_if.FWDAUX1_in)) begin
            // Fullness is judged before any same-cycle pop
            rsp_valid_d = 1'b1;
            if (!full) begin
                push       = 1'b1;
                rsp_ack_d  = 1'b1;
                rx_state_d = RX_ACCEPT;
            end else begin
                rx_state_d = RX_DISCARD;
            end
        end
    end

    always_comb begin
        chk_state_d      = chk_state_q;
        flit_count_d     = flit_count_q;
        packet_count_d   = packet_count_q;
        protocol_error_d = protocol_error_q;
        dest_error_d     = dest_error_q;
        if (pop) begin
            flit_count_d = flit_count_q + COUNTWIDTH'(1);
            if (pop_type == FLIT_HEADER) begin
                // A misplaced header is flagged but still opens a new packet
                chk_state_d = RX_IN_PACKET;
                if (chk_state_q == RX_IN_PACKET) protocol_error_d = 1'b1;
                if (fifo_out[LOGNUMBEROUTPUTS+2:3] != ID) dest_error_d = 1'b1;
            end else if (chk_state_q == RX_IN_PACKET && pop_type == FLIT_TAIL) begin
                chk_state_d    = RX_WAIT_HEADER;
                packet_count_d = packet_count_q + COUNTWIDTH'(1);
            end else if (!(chk_state_q == RX_IN_PACKET && pop_type == FLIT_PAYLOAD)) begin
                protocol_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_q          <= '0;
            rx_state_q       <= RX_ACCEPT;
            rsp_valid_q      <= 1'b0;
            rsp_ack_q        <= 1'b0;
            chk_state_q      <= RX_WAIT_HEADER;
            flit_count_q     <= '0;
            packet_count_q   <= '0;
            protocol_error_q <= 1'b0;
            dest_error_q     <= 1'b0;
        end else begin
            drain_q          <= drain_d;
            rx_state_q       <= rx_state_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_ack_q        <= rsp_ack_d;
            chk_state_q      <= chk_state_d;
            flit_count_q     <= flit_count_d;
            packet_count_q   <= packet_count_d;
            protocol_error_q <= protocol_error_d;
            dest_error_q     <= dest_error_d;
        end
    end

    assign port_if.BWDAUX1_out = (FC_MODE == FC_STALLGO) ? full : rsp_ack_q;
    assign port_if.BWDAUX2_out = (FC_MODE == FC_STALLGO) ? 1'b0 : rsp_valid_q;
    assign port_if.BWDAUX3_out = 1'b0;

    assign flit_count     = flit_count_q;
    assign packet_count   = packet_count_q;
    assign protocol_error = protocol_error_q;
    assign dest_error     = dest_error_q;
endmodule

// File: tb/tb_switch_power_tester_output.sv
// Bench for the output-port sink: three instances (STALLGO drain 1, STALLGO
// drain 4, ACKNACK drain 8) share one stimulus stream.
module tb_switch_power_tester_output;
    import switch_power_tester_output_pkg::*;

    localparam logic [31:0] H2 = 32'hA5A5_0013;  // header, dest 2
    localparam logic [31:0] H1 = 32'h0000_000B;  // header, dest 1
    localparam logic [31:0] PL = 32'h1234_5672;  // payload
    localparam logic [31:0] TL = 32'hCAFE_0008;  // tail

    typedef struct packed {
        logic        b1, b2, b3;
        logic [15:0] fc, pc;
        logic        pe, de;
    } obs_t;

    typedef struct {
        int          inst;
        bit          rst_before;
        logic [1:0]  id;
        logic        valid;
        logic        fwd;
        logic [31:0] flit;
        obs_t        exp;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [1:0]  id    = 2'd0;
    logic [31:0] flit  = '0;
    logic        valid = 1'b0;
    logic        fwd   = 1'b0;

    logic [15:0] fc0, fc1, fc2, pc0, pc1, pc2;
    logic        pe0, pe1, pe2, de0, de1, de2;
    obs_t        obs0, obs1, obs2;

    int errors = 0;
    int checks = 0;

    fc_mode_e inst_mode [3] = '{FC_STALLGO, FC_STALLGO, FC_ACKNACK};
    int       inst_dp   [3] = '{1, 4, 8};

    // reference model state
    logic [31:0] mq[$];
    int          m_drain, m_fc, m_pc;
    bit          m_disc, m_rv, m_ra, m_inpkt, m_pe, m_de;

    always #5 clk = ~clk;

    switch_power_tester_output_if #(.FLITWIDTH(32)) if_s1 ();
    switch_power_tester_output_if #(.FLITWIDTH(32)) if_s4 ();
    switch_power_tester_output_if #(.FLITWIDTH(32)) if_a8 ();

    assign if_s1.FLIT_in = flit;  assign if_s1.VALID_in = valid;  assign if_s1.FWDAUX1_in = fwd;
    assign if_s4.FLIT_in = flit;  assign if_s4.VALID_in = valid;  assign if_s4.FWDAUX1_in = fwd;
    assign if_a8.FLIT_in = flit;  assign if_a8.VALID_in = valid;  assign if_a8.FWDAUX1_in = fwd;

    switch_power_tester_output #(.DRAINPERIOD(1), .FC_MODE(FC_STALLGO)) u_s1 (
        .clk(clk), .rst(rst), .ID(id), .port_if(if_s1),
        .flit_count(fc0), .packet_count(pc0), .protocol_error(pe0), .dest_error(de0));
    switch_power_tester_output #(.DRAINPERIOD(4), .FC_MODE(FC_STALLGO)) u_s4 (
        .clk(clk), .rst(rst), .ID(id), .port_if(if_s4),
        .flit_count(fc1), .packet_count(pc1), .protocol_error(pe1), .dest_error(de1));
    switch_power_tester_output #(.DRAINPERIOD(8), .FC_MODE(FC_ACKNACK)) u_a8 (
        .clk(clk), .rst(rst), .ID(id), .port_if(if_a8),
        .flit_count(fc2), .packet_count(pc2), .protocol_error(pe2), .dest_error(de2));

    assign obs0 = {if_s1.BWDAUX1_out, if_s1.BWDAUX2_out, if_s1.BWDAUX3_out, fc0, pc0, pe0, de0};
    assign obs1 = {if_s4.BWDAUX1_out, if_s4.BWDAUX2_out, if_s4.BWDAUX3_out, fc1, pc1, pe1, de1};
    assign obs2 = {if_a8.BWDAUX1_out, if_a8.BWDAUX2_out, if_a8.BWDAUX3_out, fc2, pc2, pe2, de2};

    function automatic obs_t get_obs(int inst);
        case (inst)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic obs_t ob(bit b1, bit b2, int fcv, int pcv, bit pe, bit de);
        obs_t o;
        o.b1 = b1; o.b2 = b2; o.b3 = 1'b0;
        o.fc = 16'(fcv); o.pc = 16'(pcv);
        o.pe = pe; o.de = de;
        return o;
    endfunction

    function automatic vec_t mk(int inst, bit rb, logic [1:0] vid, logic v, logic f,
                                logic [31:0] fl, obs_t e);
        vec_t r;
        r.inst = inst; r.rst_before = rb; r.id = vid;
        r.valid = v; r.fwd = f; r.flit = fl; r.exp = e;
        return r;
    endfunction

    function automatic logic [31:0] rand_flit();
        logic [31:0] f;
        int          k;
        f = $urandom;
        k = $urandom_range(0, 9);
        if (k < 3)      f[2:0] = 3'b011;
        else if (k < 7) f[2:0] = 3'b010;
        else if (k < 9) f[2:0] = 3'b000;
        else            f[2:0] = 3'b101;
        return f;
    endfunction

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, inst, act, exp);
        end
    endtask

    task automatic chk_obs(string tag, int inst, obs_t exp);
        obs_t act;
        act = get_obs(inst);
        chk({tag, ".bwd1"},  inst, 32'(act.b1), 32'(exp.b1));
        chk({tag, ".bwd2"},  inst, 32'(act.b2), 32'(exp.b2));
        chk({tag, ".bwd3"},  inst, 32'(act.b3), 32'(exp.b3));
        chk({tag, ".flits"}, inst, 32'(act.fc), 32'(exp.fc));
        chk({tag, ".pkts"},  inst, 32'(act.pc), 32'(exp.pc));
        chk({tag, ".perr"},  inst, 32'(act.pe), 32'(exp.pe));
        chk({tag, ".derr"},  inst, 32'(act.de), 32'(exp.de));
    endtask

    // Asserts reset mid-cycle, confirms the asynchronous clear, releases it
    // just after a rising edge so the next edge is the first active one.
    task automatic do_reset();
        valid = 1'b0; fwd = 1'b0; flit = '0;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_obs("reset", i, ob(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain = 0; m_fc = 0; m_pc = 0;
        m_disc = 0; m_rv = 0; m_ra = 0; m_inpkt = 0; m_pe = 0; m_de = 0;
    endtask

    // One clock of the sink, written from the behavioural rules with a queue.
    task automatic model_step(fc_mode_e mode, int dp, bit v, bit fw,
                              logic [31:0] f, logic [1:0] myid);
        bit          was_full, do_pop, do_push, rv, ra;
        logic [31:0] head;
        was_full = (mq.size() == 4);
        do_pop   = (m_drain == 0) && (mq.size() > 0);
        do_push  = 0; rv = 0; ra = 0;
        if (mode == FC_STALLGO) begin
            do_push = v && !was_full;
        end else if (v && (!m_disc || fw)) begin
            rv = 1;
            if (!was_full) begin do_push = 1; ra = 1; m_disc = 0; end
            else m_disc = 1;
        end
        if (do_pop) begin
            head = mq.pop_front();
            m_fc++;
            case (head[2:0])
                3'b011: begin
                    if (m_inpkt) m_pe = 1;
                    m_inpkt = 1;
                    if (head[4:3] != myid) m_de = 1;
                end
                3'b010: if (!m_inpkt) m_pe = 1;
                3'b000: begin
                    if (m_inpkt) begin m_inpkt = 0; m_pc++; end
                    else m_pe = 1;
                end
                default: m_pe = 1;
            endcase
        end
        if (do_push) mq.push_back(f);
        m_drain = (m_drain + 1) % dp;
        m_rv = rv; m_ra = ra;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] seq [8];
        int          sent;
        bit          saw_stall, acc;
        obs_t        e;

        // STALLGO drain 1, ID=2: clean packet back-to-back
        vecs.push_back(mk(0, 1, 2'd2, 1, 0, H2, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd2, 1, 0, PL, ob(0, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd2, 1, 0, PL, ob(0, 0, 2, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd2, 1, 0, TL, ob(0, 0, 3, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd2, 0, 0, '0, ob(0, 0, 4, 1, 0, 0)));
        // ACKNACK drain 8: fill, NACK, silent discard, replay NACK then ACK
        vecs.push_back(mk(2, 1, 2'd2, 1, 0, H2, ob(1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 1, PL, ob(0, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 1, PL, ob(1, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 1, 0, PL, ob(0, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(2, 0, 2'd2, 0, 0, '0, ob(0, 0, 1, 0, 0, 0)));
        // payload before any header
        vecs.push_back(mk(0, 1, 2'd0, 1, 0, PL, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd0, 0, 0, '0, ob(0, 0, 1, 0, 1, 0)));
        // header dest=1 at ID=3: dest_error, packet still counted
        vecs.push_back(mk(0, 1, 2'd3, 1, 0, H1, ob(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2'd3, 1, 0, TL, ob(0, 0, 1, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 2'd3, 0, 0, '0, ob(0, 0, 2, 1, 0, 1)));

        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_obs("por", i, ob(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            id = vecs[k].id; valid = vecs[k].valid; fwd = vecs[k].fwd; flit = vecs[k].flit;
            @(posedge clk);
            #1;
            chk_obs($sformatf("vec%0d", k), vecs[k].inst, vecs[k].exp);
            e = get_obs(vecs[k].inst);
            $display("vec %0d inst=%0d v=%0b fwd=%0b flit=%08h -> bwd1=%0b bwd2=%0b flits=%0d pkts=%0d perr=%0b derr=%0b",
                     k, vecs[k].inst, valid, fwd, flit, e.b1, e.b2, e.fc, e.pc, e.pe, e.de);
        end

        // STALLGO drain 4: eight flits offered continuously, honouring stall
        do_reset();
        id = 2'd1;
        seq[0] = H1;
        for (int i = 1; i < 7; i++) seq[i] = PL;
        seq[7] = TL;
        sent = 0; saw_stall = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            valid = (sent < 8);
            flit  = seq[(sent < 8) ? sent : 7];
            acc   = valid && !obs1.b1;
            @(posedge clk);
            #1;
            if (acc) begin
                $display("stallgo accept #%0d flit=%08h cyc=%0d", sent, flit, cyc);
                sent++;
            end
            if (obs1.b1) saw_stall = 1;
            if (cyc == 3) chk("full_at_4", 1, 32'(obs1.b1), 32'd1);
            if (obs1.fc == 16'd8) break;
        end
        valid = 1'b0;
        chk("sg_sent", 1, 32'(sent), 32'd8);
        chk("sg_saw_stall", 1, 32'(saw_stall), 32'd1);
        chk_obs("sg_final", 1, ob(0, 0, 8, 1, 0, 0));

        // Reset mid-packet with three flits buffered in the drain-8 instance
        do_reset();
        id = 2'd2;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            flit  = (i == 0) ? H2 : PL;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        chk("pre_rst_ack", 2, 32'(obs2.b2), 32'd1);
        chk("pre_rst_s1_flits", 0, 32'(obs0.fc), 32'd2);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_obs("async_rst", i, ob(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        valid = 1'b1; flit = H2;
        @(posedge clk);
        #1;
        chk_obs("post_rst_ack", 2, ob(1, 1, 0, 0, 0, 0));
        $display("post-reset header flit=%08h bwd1=%0b bwd2=%0b", flit, obs2.b1, obs2.b2);
        flit = TL;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk_obs("post_rst_a8", 2, ob(0, 0, 2, 1, 0, 0));
        chk_obs("post_rst_s1", 0, ob(0, 0, 2, 1, 0, 0));

        // Randomized traffic against the queue model, one instance at a time
        for (int inst = 0; inst < 3; inst++) begin
            id = 2'($urandom_range(0, 3));
            do_reset();
            model_reset();
            for (int c = 0; c < 150; c++) begin
                valid = ($urandom_range(0, 9) < 7);
                fwd   = ($urandom_range(0, 3) == 0);
                flit  = rand_flit();
                model_step(inst_mode[inst], inst_dp[inst], valid, fwd, flit, id);
                @(posedge clk);
                #1;
                if (inst_mode[inst] == FC_STALLGO)
                    e = ob(mq.size() == 4, 0, m_fc, m_pc, m_pe, m_de);
                else
                    e = ob(m_ra, m_rv, m_fc, m_pc, m_pe, m_de);
                chk_obs($sformatf("rnd%0d_%0d", inst, c), inst, e);
                if (valid)
                    $display("rnd inst=%0d cyc=%0d flit=%08h fwd=%0b -> bwd1=%0b bwd2=%0b flits=%0d",
                             inst, c, flit, fwd, get_obs(inst).b1, get_obs(inst).b2, get_obs(inst).fc);
            end
        end
        valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
